// File: rtl/lvg_mac_array.sv
// NxN signed integer matrix multiply-accumulate engine with row-wide load/read handshakes.
// All N*N MACs fire together, one inner-product term per cycle.
module lvg_mac_array #(
  parameter int N     = 4,
  parameter int W     = 16,
  parameter int ACC_W = 40,
  parameter int RW    = ($clog2(N) > 1) ? $clog2(N) : 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 cmd_valid,
  output logic                 cmd_ready,
  input  logic [2:0]           cmd_op,
  input  logic [RW-1:0]        cmd_row,
  input  logic [N*W-1:0]       cmd_data,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [RW-1:0]        out_row,
  output logic [N*ACC_W-1:0]   out_data,
  output logic                 busy
);

  typedef enum logic [1:0] {S_IDLE, S_COMPUTE, S_DRAIN} state_t;
  typedef enum logic [2:0] {
    OP_NOP, OP_LOAD_L, OP_LOAD_R, OP_LOAD_A, OP_MUL, OP_MAC, OP_MAC_T, OP_READ
  } op_t;

  state_t state, state_next;
  op_t    op;

  logic signed [W-1:0]     l_m  [N][N];
  logic signed [W-1:0]     r_m  [N][N];
  logic        [ACC_W-1:0] a_m  [N][N];
  logic        [ACC_W-1:0] b_m  [N][N];
  logic signed [2*W-1:0]   prod [N][N];
  logic        [RW-1:0]    k;
  logic        [RW-1:0]    cnt;
  logic                    trans;
  logic                    accept;
  logic                    row_ok;

  assign op        = op_t'(cmd_op);
  assign cmd_ready = (state == S_IDLE);
  assign busy      = !cmd_ready;
  assign out_valid = (state == S_DRAIN);
  assign out_row   = cnt;
  assign accept    = cmd_valid && cmd_ready;
  assign row_ok    = (32'(cmd_row) < N);

  always_comb begin
    state_next = state;
    unique case (state)
      S_IDLE: begin
        if (cmd_valid) begin
          if (op == OP_MUL || op == OP_MAC || op == OP_MAC_T) state_next = S_COMPUTE;
          else if (op == OP_READ)                              state_next = S_DRAIN;
        end
      end
      S_COMPUTE: if (k == RW'(N-1)) state_next = S_IDLE;
      S_DRAIN:   if (out_ready && cnt == RW'(N-1)) state_next = S_IDLE;
      default:   state_next = S_IDLE;
    endcase
  end

  // MAC_T picks the column of L instead of the row, so B = L^T * R.
  always_comb begin
    for (int unsigned i = 0; i < N; i++)
      for (int unsigned j = 0; j < N; j++)
        prod[i][j] = (trans ? l_m[k][i] : l_m[i][k]) * r_m[k][j];
  end

  always_comb begin
    out_data = '0;
    if (state == S_DRAIN)
      for (int unsigned j = 0; j < N; j++)
        out_data[j*ACC_W +: ACC_W] = b_m[cnt][j];
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= S_IDLE;
      k     <= '0;
      cnt   <= '0;
      trans <= 1'b0;
      for (int unsigned i = 0; i < N; i++)
        for (int unsigned j = 0; j < N; j++) begin
          l_m[i][j] <= '0;
          r_m[i][j] <= '0;
          a_m[i][j] <= '0;
          b_m[i][j] <= '0;
        end
    end else begin
      state <= state_next;
      unique case (state)
        S_IDLE: begin
          if (accept) begin
            unique case (op)
              OP_LOAD_L: if (row_ok)
                for (int unsigned j = 0; j < N; j++) l_m[cmd_row][j] <= cmd_data[j*W +: W];
              OP_LOAD_R: if (row_ok)
                for (int unsigned j = 0; j < N; j++) r_m[cmd_row][j] <= cmd_data[j*W +: W];
              OP_LOAD_A: if (row_ok)
                for (int unsigned j = 0; j < N; j++)
                  a_m[cmd_row][j] <= ACC_W'($signed(cmd_data[j*W +: W]));
              OP_MUL, OP_MAC, OP_MAC_T: begin
                k     <= '0;
                trans <= (op == OP_MAC_T);
                for (int unsigned i = 0; i < N; i++)
                  for (int unsigned j = 0; j < N; j++)
                    b_m[i][j] <= (op == OP_MUL) ? '0 : a_m[i][j];
              end
              OP_READ: cnt <= '0;
              default: ;
            endcase
          end
        end
        S_COMPUTE: begin
          k <= k + RW'(1);
          for (int unsigned i = 0; i < N; i++)
            for (int unsigned j = 0; j < N; j++)
              b_m[i][j] <= b_m[i][j] + ACC_W'(prod[i][j]);
        end
        S_DRAIN: if (out_ready) cnt <= cnt + RW'(1);
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_lvg_mac_array.sv
// Self-checking bench for lvg_mac_array: directed vector table, hand-written corner
// sequences and randomized matrices checked against a plain-arithmetic matrix model.
module tb_lvg_mac_array;
  localparam int N = 4, W = 16, ACC_W = 40, RW = 2;

  logic               clk = 1'b0;
  logic               rst = 1'b0;
  logic               cmd_valid = 1'b0;
  logic               cmd_ready;
  logic [2:0]         cmd_op = '0;
  logic [RW-1:0]      cmd_row = '0;
  logic [N*W-1:0]     cmd_data = '0;
  logic               out_valid;
  logic               out_ready = 1'b1;
  logic [RW-1:0]      out_row;
  logic [N*ACC_W-1:0] out_data;
  logic               busy;

  lvg_mac_array #(.N(N), .W(W), .ACC_W(ACC_W)) dut (
    .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_op(cmd_op), .cmd_row(cmd_row), .cmd_data(cmd_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_row(out_row),
    .out_data(out_data), .busy(busy)
  );

  always #5 clk = ~clk;

  longint mL [N][N], mR [N][N], mA [N][N], mB [N][N];
  logic [ACC_W-1:0] got [N][N];
  int tests = 0, fails = 0;

  function automatic void check(string name, logic [63:0] act, logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endfunction

  function automatic void model_clear();
    for (int i = 0; i < N; i++)
      for (int j = 0; j < N; j++) begin
        mL[i][j] = 0; mR[i][j] = 0; mA[i][j] = 0; mB[i][j] = 0;
      end
  endfunction

  // B = L*R, L*R + A or L^T*R + A with plain integer sums.
  function automatic void model_compute(int op);
    for (int i = 0; i < N; i++)
      for (int j = 0; j < N; j++) begin
        longint s = (op == 4) ? 0 : mA[i][j];
        for (int kk = 0; kk < N; kk++)
          s += ((op == 6) ? mL[kk][i] : mL[i][kk]) * mR[kk][j];
        mB[i][j] = s;
      end
  endfunction

  function automatic logic [63:0] exp40(longint v);
    logic [63:0] t = v;
    return {24'b0, t[39:0]};
  endfunction

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic send(int op, int row, logic [N*W-1:0] data);
    int n = 0;
    cmd_valid = 1'b1; cmd_op = op[2:0]; cmd_row = row[RW-1:0]; cmd_data = data;
    while (!cmd_ready && n < 50) begin tick(); n++; end
    if (n == 50) check("cmd_ready_timeout", 64'd0, 64'd1);
    tick();
    cmd_valid = 1'b0;
    if (op >= 1 && op <= 3 && row < N)
      for (int j = 0; j < N; j++) begin
        logic signed [W-1:0] e = data[j*W +: W];
        if (op == 1) mL[row][j] = e;
        else if (op == 2) mR[row][j] = e;
        else mA[row][j] = e;
      end
    if (op >= 4 && op <= 6) model_compute(op);
  endtask

  task automatic load_row(int op, int row, longint v0, longint v1, longint v2, longint v3);
    logic [N*W-1:0] d;
    longint v [N];
    v[0] = v0; v[1] = v1; v[2] = v2; v[3] = v3;
    for (int j = 0; j < N; j++) d[j*W +: W] = v[j][W-1:0];
    send(op, row, d);
  endtask

  task automatic zero_all();
    for (int op = 1; op <= 3; op++)
      for (int r = 0; r < N; r++) load_row(op, r, 0, 0, 0, 0);
  endtask

  // Optionally presents a LOAD_L during COMPUTE, which must not be accepted.
  task automatic run_compute(int op, bit probe);
    int n = 0;
    send(op, 0, '0);
    if (probe) begin
      cmd_valid = 1'b1; cmd_op = 3'd1; cmd_row = '0; cmd_data = '1;
    end
    while (busy && n < 20) begin tick(); n++; end
    cmd_valid = 1'b0;
    check("busy_cycles", n, N);
  endtask

  task automatic read_check(string name, bit stall);
    send(7, 0, '0);
    for (int r = 0; r < N; r++) begin
      if (stall && r == 0) begin
        out_ready = 1'b0;
        for (int s = 0; s < 3; s++) begin
          tick();
          check({name, "_stall_valid"}, out_valid, 1);
          check({name, "_stall_row"}, out_row, 0);
          check({name, "_stall_data"}, out_data[0 +: ACC_W], exp40(mB[0][0]));
        end
        out_ready = 1'b1;
      end
      check({name, "_valid"}, out_valid, 1);
      check({name, "_row"}, out_row, r);
      for (int j = 0; j < N; j++) begin
        got[r][j] = out_data[j*ACC_W +: ACC_W];
        check({name, "_data"}, got[r][j], exp40(mB[r][j]));
      end
      tick();
    end
    check({name, "_done_valid"}, out_valid, 0);
    check({name, "_done_ready"}, cmd_ready, 1);
  endtask

  typedef struct {
    int          op;
    longint      l00, r00, a00;
    logic [39:0] exp_b00;
  } vec_t;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    vec_t vecs [5];
    vecs[0] = '{4, -32768, -32768,      0, 40'h0040000000};
    vecs[1] = '{5, -32768, -32768, -32768, 40'h003FFF8000};
    vecs[2] = '{6,  32767, -32768,    100, 40'hFFC0008064};
    vecs[3] = '{5,      7,     -3,      1, 40'hFFFFFFFFEC};
    vecs[4] = '{4,     -1,      1,    123, 40'hFFFFFFFFFF};

    model_clear();
    repeat (3) tick();
    check("rst_cmd_ready", cmd_ready, 1);
    check("rst_busy", busy, 0);
    check("rst_out_valid", out_valid, 0);
    check("rst_out_row", out_row, 0);
    check("rst_out_data", out_data[63:0], 0);
    rst = 1'b1;
    tick();
    check("post_rst_ready", cmd_ready, 1);
    read_check("rst_read", 0);

    // Identity multiply with a probe command during COMPUTE.
    for (int r = 0; r < N; r++) begin
      load_row(1, r, r == 0, r == 1, r == 2, r == 3);
      load_row(2, r, r + 1, r + 2, r + 3, r + 4);
    end
    run_compute(4, 1);
    read_check("ident", 0);
    check("ident_b23", got[2][3], 6);
    check("ident_b00", got[0][0], 1);

    // NOP and out-of-range rows cannot change anything; re-read is identical.
    send(0, 0, '1);
    read_check("nop_reread", 0);

    for (int r = 0; r < N; r++) begin
      load_row(1, r, 1, 1, 1, 1);
      load_row(2, r, 2, 2, 2, 2);
      load_row(3, r, 5, 5, 5, 5);
    end
    run_compute(5, 0);
    read_check("mac_all", 1);
    check("mac_all_b33", got[3][3], 13);
    check("mac_all_b00", got[0][0], 13);

    zero_all();
    for (int v = 0; v < 5; v++) begin
      load_row(1, 0, vecs[v].l00, 0, 0, 0);
      load_row(2, 0, vecs[v].r00, 0, 0, 0);
      load_row(3, 0, vecs[v].a00, 0, 0, 0);
      run_compute(vecs[v].op, 0);
      read_check("vec", 0);
      check("vec_b00", got[0][0], {24'b0, vecs[v].exp_b00});
    end

    zero_all();
    load_row(1, 1, 3, 0, 0, 0);
    load_row(2, 1, 4, 0, 0, 0);
    run_compute(6, 0);
    read_check("mac_t", 0);
    check("mac_t_b00", got[0][0], 12);
    run_compute(5, 0);
    read_check("mac_same", 0);
    check("mac_same_b00", got[0][0], 0);

    for (int it = 0; it < 6; it++) begin
      for (int op = 1; op <= 3; op++)
        for (int r = 0; r < N; r++) begin
          logic signed [W-1:0] e [N];
          for (int j = 0; j < N; j++) e[j] = W'($urandom);
          load_row(op, r, e[0], e[1], e[2], e[3]);
        end
      run_compute(4 + $urandom_range(0, 2), 0);
      read_check("rand", it == 2);
    end

    // Abort at k = 2: every register returns to its reset value.
    send(5, 0, '0);
    tick(); tick();
    rst = 1'b0;
    #1;
    check("abort_ready", cmd_ready, 1);
    check("abort_busy", busy, 0);
    check("abort_valid", out_valid, 0);
    model_clear();
    tick();
    rst = 1'b1;
    tick();
    read_check("abort_read", 0);
    run_compute(5, 0);
    read_check("abort_operands", 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
